// File: rtl/sdram_burst_reader_pkg.sv
// Shared types and widths for the SDRAM burst reader.
package sdram_burst_reader_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 9;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

endpackage

// File: rtl/sdram_burst_reader.sv
// Splits a video burst request into single-word SDRAM reads and returns data.
// Optional BURST_READER_DROP_COUNT_EN adds a saturating ignored-request counter.
module sdram_burst_reader
    import sdram_burst_reader_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_request,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic [LEN_W-1:0]  rd_burst_length,
    output logic              rd_available,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
`ifdef BURST_READER_DROP_COUNT_EN
    output logic [7:0]        dropped_requests,
`endif
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_cmd_address,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t            state;
    state_t            state_nx;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  outstanding;
    logic              start;
    logic              cmd_fire;
    logic              rsp_take;

    assign start    = rd_request && (state == IDLE)
                      && (rd_burst_length != '0);
    assign mem_cmd_valid = (state == ISSUE)
                           && (remaining != '0)
                           && (outstanding < MAX_CNT);
    assign cmd_fire = mem_cmd_valid && mem_cmd_ready;
    // Responses with nothing in flight are stale (e.g. after reset).
    assign rsp_take = mem_rsp_valid && (outstanding != '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: if (cmd_fire && remaining == LEN_W'(1))
                       state_nx = DRAIN;
            DRAIN: if (outstanding == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cmd_address <= '0;
            remaining       <= '0;
        end else if (start) begin
            mem_cmd_address <= rd_address;
            remaining       <= rd_burst_length;
        end else if (cmd_fire) begin
            mem_cmd_address <= mem_cmd_address + ADDR_W'(1);
            remaining       <= remaining - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            unique case ({cmd_fire, rsp_take})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_available <= 1'b0;
            rd_data      <= '0;
        end else begin
            rd_available <= rsp_take;
            if (rsp_take) rd_data <= mem_rsp_data;
        end
    end

`ifdef BURST_READER_DROP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_requests <= '0;
        end else if (rd_request && (state != IDLE)
                     && (dropped_requests != 8'hFF)) begin
            dropped_requests <= dropped_requests + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench for sdram_burst_reader with a simple SDRAM responder.
module tb_sdram_burst_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_request = 1'b0;
    logic [22:0] rd_address = '0;
    logic [8:0]  rd_burst_length = '0;
    logic        rd_available;
    logic [31:0] rd_data;
    logic        busy;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b0;
    logic [22:0] mem_cmd_address;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
`ifdef BURST_READER_DROP_COUNT_EN
    logic [7:0]  dropped_requests;
`endif

    always #5 clk = ~clk;

    sdram_burst_reader #(.MAX_OUTSTANDING(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .rd_request      (rd_request),
        .rd_address      (rd_address),
        .rd_burst_length (rd_burst_length),
        .rd_available    (rd_available),
        .rd_data         (rd_data),
        .busy            (busy),
`ifdef BURST_READER_DROP_COUNT_EN
        .dropped_requests(dropped_requests),
`endif
        .mem_cmd_valid   (mem_cmd_valid),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_cmd_address (mem_cmd_address),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          rd_cnt = 0;
    int          stall_until = 0;
    int          stray_until = 0;
    logic        hold_rsp = 1'b0;
    logic        hold_prev = 1'b0;
    logic [22:0] hold_addr = '0;
    logic [22:0] exp_addr[$];
    logic [31:0] exp_data[$];
    rsp_t        pending[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [22:0] a);
        return {a[7:0], 1'b1, a} ^ 32'h5A00_0000;
    endfunction

    task automatic push_burst(logic [22:0] a, int n);
        for (int i = 0; i < n; i++) begin
            logic [22:0] x;
            x = a + 23'(i);
            exp_addr.push_back(x);
            exp_data.push_back(mem_word(x));
        end
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic req(logic [22:0] a, logic [8:0] len);
        rd_address      = a;
        rd_burst_length = len;
        rd_request      = 1'b1;
        step(1);
        rd_request      = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int k;
        k = 0;
        step(1);
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        chk("drain_left", 32'(exp_data.size()), 32'd0);
    endtask

    // SDRAM side: acceptance, 3-cycle responses, output scoreboard.
    always @(negedge clk) begin
        rsp_t r;
        if (!reset && hold_prev) begin
            chk("hold_valid", 32'(mem_cmd_valid), 32'd1);
            chk("hold_addr", 32'(mem_cmd_address), 32'(hold_addr));
        end
        mem_cmd_ready = !(cyc < stall_until);
        hold_prev = !reset && mem_cmd_valid && !mem_cmd_ready;
        hold_addr = mem_cmd_address;
        if (!reset && mem_cmd_valid && mem_cmd_ready) begin
            acc_cnt++;
            if (exp_addr.size() == 0)
                chk("cmd_unexp", 32'(mem_cmd_address), 32'hFFFF_FFFF);
            else
                chk("cmd_addr", 32'(mem_cmd_address),
                    32'(exp_addr.pop_front()));
            r.due  = cyc + 3;
            r.data = mem_word(mem_cmd_address);
            pending.push_back(r);
        end
        if (rd_available) begin
            rd_cnt++;
            if (exp_data.size() == 0)
                chk("rd_unexp", rd_data, 32'hDEAD_BEEF);
            else
                chk("rd_data", rd_data, exp_data.pop_front());
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (cyc < stray_until) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
        end else if (!hold_rsp && pending.size() != 0
                     && pending[0].due <= cyc) begin
            r = pending.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = r.data;
        end
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int rd0;
        int k;

        step(2);
        chk("rst_valid", 32'(mem_cmd_valid), 32'd0);
        chk("rst_addr", 32'(mem_cmd_address), 32'd0);
        chk("rst_rdav", 32'(rd_available), 32'd0);
        chk("rst_rdata", rd_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef BURST_READER_DROP_COUNT_EN
        chk("rst_drop", 32'(dropped_requests), 32'd0);
`endif
        reset = 1'b0;
        step(2);

        // Long burst, ready always high
        acc0 = acc_cnt;
        rd0  = rd_cnt;
        push_burst(23'h000100, 80);
        req(23'h000100, 9'd80);
        chk("busy_rise", 32'(busy), 32'd1);
        wait_idle(400);
        chk("b1_cmds", 32'(acc_cnt - acc0), 32'd80);
        chk("b1_pulses", 32'(rd_cnt - rd0), 32'd80);

        // Back-pressure for 10 cycles mid-burst
        acc0 = acc_cnt;
        push_burst(23'h002000, 20);
        req(23'h002000, 9'd20);
        step(6);
        stall_until = cyc + 10;
        wait_idle(200);
        chk("b2_cmds", 32'(acc_cnt - acc0), 32'd20);

        // Outstanding limit with responses withheld
        hold_rsp = 1'b1;
        acc0 = acc_cnt;
        push_burst(23'h003000, 8);
        req(23'h003000, 9'd8);
        step(20);
        chk("os_cmds", 32'(acc_cnt - acc0), 32'd4);
        chk("os_valid", 32'(mem_cmd_valid), 32'd0);
        hold_rsp = 1'b0;
        wait_idle(200);
        chk("os_total", 32'(acc_cnt - acc0), 32'd8);

        // Address wrap at the top of the space
        acc0 = acc_cnt;
        push_burst(23'h7FFFFE, 4);
        req(23'h7FFFFE, 9'd4);
        wait_idle(100);
        chk("wrap_cmds", 32'(acc_cnt - acc0), 32'd4);

        // Zero-length request, then a request while busy
        acc0 = acc_cnt;
        req(23'h004000, 9'd0);
        step(3);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_cmds", 32'(acc_cnt - acc0), 32'd0);
        push_burst(23'h005000, 4);
        req(23'h005000, 9'd4);
        req(23'h006000, 9'd3);
        wait_idle(100);
        chk("ign_cmds", 32'(acc_cnt - acc0), 32'd4);
`ifdef BURST_READER_DROP_COUNT_EN
        chk("dropped", 32'(dropped_requests), 32'd1);
`endif

        // Reset mid-burst, then stray responses
        acc0 = acc_cnt;
        push_burst(23'h000100, 80);
        req(23'h000100, 9'd80);
        k = 0;
        while ((acc_cnt - acc0) < 5 && k < 50) begin
            step(1);
            k++;
        end
        chk("rst_pre", 32'((acc_cnt - acc0) >= 5), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_valid", 32'(mem_cmd_valid), 32'd0);
        chk("mrst_addr", 32'(mem_cmd_address), 32'd0);
        chk("mrst_rdav", 32'(rd_available), 32'd0);
        chk("mrst_rdata", rd_data, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        pending.delete();
        step(2);
        reset = 1'b0;
        rd0 = rd_cnt;
        acc0 = acc_cnt;
        stray_until = cyc + 3;
        step(10);
        chk("stray_rdav", 32'(rd_cnt - rd0), 32'd0);
        chk("stray_cmds", 32'(acc_cnt - acc0), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_rdata", rd_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_burst_reader.md
SDRAM_BURST_READER -- requirements
Module: sdram_burst_reader

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of issued SDRAM reads awaiting a response (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is in this domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rd_request  input  1  one-cycle burst start pulse from the video controller.
REQ-005 SHALL have port rd_address  input  23  first word address of the burst.
REQ-006 SHALL have port rd_burst_length  input  9  number of 32-bit words in the burst (0..511).
REQ-007 SHALL have port rd_available  output  1  high for exactly one cycle per returned word.
REQ-008 SHALL have port rd_data  output  32  returned word; valid only while rd_available is high.
REQ-009 SHALL have port busy  output  1  high while a burst is being issued or drained.
REQ-010 SHALL have port mem_cmd_valid  output  1  read command valid toward the SDRAM controller.
REQ-011 SHALL have port mem_cmd_ready  input  1  SDRAM controller accepts the command this cycle.
REQ-012 SHALL have port mem_cmd_address  output  23  word address of the current command.
REQ-013 SHALL have port mem_rsp_valid  input  1  SDRAM controller read data valid.
REQ-014 SHALL have port mem_rsp_data  input  32  SDRAM controller read data.

Function
REQ-015 SHALL implement the states IDLE, ISSUE and DRAIN.
REQ-016 IDLE: on rd_request with rd_burst_length != 0, SHALL latch the address and length, then enter ISSUE on the next cycle.
REQ-017 IDLE: on rd_request with length 0, SHALL remain in IDLE with no command and no data.
REQ-018 ISSUE: SHALL drive mem_cmd_valid=1 whenever remaining>0 and outstanding<MAX_OUTSTANDING; otherwise mem_cmd_valid=0.
REQ-019 SHALL hold mem_cmd_address stable while mem_cmd_valid=1 and mem_cmd_ready=0.
REQ-020 On mem_cmd_valid && mem_cmd_ready: address+1 (modulo 2^23, wrapping 7FFFFF→0), remaining-1, outstanding+1.
REQ-021 ISSUE→DRAIN in the cycle after the last command is accepted (remaining reaches 0).
REQ-022 DRAIN→IDLE when outstanding==0; if outstanding is already 0, DRAIN SHALL last exactly one cycle.
REQ-023 On mem_rsp_valid with outstanding>0: outstanding-1, rd_available=1 and rd_data=mem_rsp_data on the following cycle (1-cycle registered latency).
REQ-024 Simultaneous command acceptance and response SHALL leave outstanding unchanged.
REQ-025 mem_rsp_valid while outstanding==0 SHALL be discarded: no rd_available pulse and no counter change.
REQ-026 rd_request while busy=1 SHALL be ignored; the in-flight burst is unaffected.
REQ-027 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE (registered from state).
REQ-028 Total rd_available pulses per accepted burst SHALL equal its rd_burst_length, in command order.

Reset
REQ-029 Asynchronous reset SHALL force state=IDLE, outstanding=0, remaining=0, mem_cmd_valid=0, mem_cmd_address=0, rd_available=0, rd_data=0, busy=0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; responses arriving after reset release SHALL be discarded per REQ-025.

Configuration
REQ-031 Macro BURST_READER_DROP_COUNT_EN defined: SHALL add output dropped_requests (8 bits), reset 0, incremented once per rd_request ignored under REQ-026 and saturating at 255.
REQ-032 Macro undefined: the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The shared package SHALL hold the state enum (IDLE/ISSUE/DRAIN) and the constants ADDR_W=23, DATA_W=32 and LEN_W=9.
REQ-034 SHALL be a single module with no sub-module; the outstanding counter width SHALL be 4 bits.

Verification
REQ-035 Request addr=0x000100, len=80, mem_cmd_ready tied 1, responses 3 cycles later -> 80 commands at 0x100..0x14F, 80 rd_available pulses in order, busy falls after the last pulse.
REQ-036 mem_cmd_ready=0 for 10 cycles mid-burst -> mem_cmd_valid held high with address stable, no duplicate or skipped addresses.
REQ-037 MAX_OUTSTANDING=4 with responses withheld -> exactly 4 commands issued, then mem_cmd_valid=0 until a response returns.
REQ-038 addr=0x7FFFFE, len=4 -> command addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
REQ-039 len=0 request, then a request while busy -> no commands for either, burst unaffected; dropped_requests=1 with the macro defined.
REQ-040 Reset asserted after 5 of 80 commands, then 3 stray responses -> all outputs at reset values, no rd_available pulses.
